// File: rtl/crypto_result_tx.sv
// rtl/crypto_result_tx.sv - in-order result buffer returning crypto completions to the core
module crypto_result_tx #(
  parameter int XLEN     = 64,
  parameter int ID_WIDTH = 4,
  parameter int DEPTH    = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       unit_valid_i,
  output logic                       unit_ready_o,
  input  logic [ID_WIDTH-1:0]        unit_id_i,
  input  logic [XLEN-1:0]            unit_data_i,
  input  logic [4:0]                 unit_rd_i,
  input  logic                       unit_we_i,
  input  logic                       commit_valid_i,
  input  logic [ID_WIDTH-1:0]        commit_id_i,
  input  logic                       commit_kill_i,
  output logic                       result_valid_o,
  input  logic                       result_ready_i,
  output logic [ID_WIDTH-1:0]        result_id_o,
  output logic [XLEN-1:0]            result_data_o,
  output logic [4:0]                 result_rd_o,
  output logic                       result_we_o,
  output logic [$clog2(DEPTH):0]     occupancy_o
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int NID = 2 ** ID_WIDTH;

  logic [ID_WIDTH-1:0] ent_id   [DEPTH];
  logic [XLEN-1:0]     ent_data [DEPTH];
  logic [4:0]          ent_rd   [DEPTH];
  logic [DEPTH-1:0]    ent_we;
  logic [DEPTH-1:0]    ent_killed;

  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       count;
  logic [NID-1:0]      committed;
  logic [NID-1:0]      kill_pending;

  logic                full;
  logic                head_live;
  logic                head_killed;
  logic [ID_WIDTH-1:0] head_id;
  logic                push;
  logic                pop;
  logic                drop;
  logic                kill_now;
  logic                enq_hit;
  logic                any_hit;
  logic                dup_hit;
  logic [DEPTH-1:0]    slot_valid;
  logic [DEPTH-1:0]    kill_hit;
  logic [DEPTH-1:0]    mark_kill;
  logic [PW-1:0]       offset;

  // Head view, handshake qualifiers and kill matching against live slots
  always_comb begin
    full           = (count == CW'(DEPTH));
    unit_ready_o   = !rst_i && !full;
    head_live      = !rst_i && (count != '0);
    head_id        = ent_id[rd_ptr];
    head_killed    = ent_killed[rd_ptr];
    result_valid_o = head_live && !head_killed && committed[head_id];
    drop           = head_live && head_killed;
    pop            = (result_valid_o && result_ready_i) || drop;
    push           = unit_valid_i && unit_ready_o;
    kill_now       = commit_valid_i && commit_kill_i;
    enq_hit        = push && (unit_id_i == commit_id_i);
    slot_valid     = '0;
    kill_hit       = '0;
    mark_kill      = '0;
    dup_hit        = 1'b0;
    offset         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset        = PW'(i) - rd_ptr;
      slot_valid[i] = ({1'b0, offset} < count);
      kill_hit[i]   = kill_now && slot_valid[i] && (ent_id[i] == commit_id_i);
      // a result already on the bus is never retracted
      mark_kill[i]  = kill_hit[i] && !(result_valid_o && (PW'(i) == rd_ptr));
      if (push && slot_valid[i] && (ent_id[i] == unit_id_i) && !(pop && (PW'(i) == rd_ptr)))
        dup_hit = 1'b1;
    end
    any_hit = |kill_hit;
  end

  // Result bus is zero whenever nothing is being offered
  always_comb begin
    result_id_o   = '0;
    result_data_o = '0;
    result_rd_o   = '0;
    result_we_o   = 1'b0;
    if (result_valid_o) begin
      result_id_o   = head_id;
      result_data_o = ent_data[rd_ptr];
      result_rd_o   = ent_rd[rd_ptr];
      result_we_o   = ent_we[rd_ptr];
    end
    occupancy_o = rst_i ? '0 : count;
  end

  // FIFO storage, pointers and the per-ID commit / early-kill tables
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      committed    <= '0;
      kill_pending <= '0;
      ent_we       <= '0;
      ent_killed   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_id[i]   <= '0;
        ent_data[i] <= '0;
        ent_rd[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (mark_kill[i]) ent_killed[i] <= 1'b1;
      end
      if (push) begin
        ent_id[wr_ptr]     <= unit_id_i;
        ent_data[wr_ptr]   <= unit_data_i;
        ent_rd[wr_ptr]     <= unit_rd_i;
        ent_we[wr_ptr]     <= unit_we_i;
        ent_killed[wr_ptr] <= kill_pending[unit_id_i] || (kill_now && enq_hit);
        wr_ptr             <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // a fresh commit of a reused ID wins over the pop clearing the old one
      if (pop) committed[head_id] <= 1'b0;
      if (commit_valid_i && !commit_kill_i) committed[commit_id_i] <= 1'b1;
      if (push) kill_pending[unit_id_i] <= 1'b0;
      if (kill_now && !any_hit && !enq_hit) kill_pending[commit_id_i] <= 1'b1;
    end
  end

  a_no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(unit_valid_i && !unit_ready_o));
  a_no_dup_id: assert property (@(posedge clk_i) disable iff (rst_i) !dup_hit);
  a_no_double_commit: assert property (@(posedge clk_i) disable iff (rst_i)
    !(commit_valid_i && !commit_kill_i && committed[commit_id_i] &&
      !(pop && (head_id == commit_id_i))));

endmodule

// File: tb/tb_crypto_result_tx.sv
// tb/tb_crypto_result_tx.sv - scoreboard bench for crypto_result_tx
module tb_crypto_result_tx;

  localparam int XLEN  = 64;
  localparam int IDW   = 4;
  localparam int DEPTH = 4;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              unit_valid_i = 1'b0;
  logic              unit_ready_o;
  logic [IDW-1:0]    unit_id_i = '0;
  logic [XLEN-1:0]   unit_data_i = '0;
  logic [4:0]        unit_rd_i = '0;
  logic              unit_we_i = 1'b0;
  logic              commit_valid_i = 1'b0;
  logic [IDW-1:0]    commit_id_i = '0;
  logic              commit_kill_i = 1'b0;
  logic              result_valid_o;
  logic              result_ready_i = 1'b0;
  logic [IDW-1:0]    result_id_o;
  logic [XLEN-1:0]   result_data_o;
  logic [4:0]        result_rd_o;
  logic              result_we_o;
  logic [$clog2(DEPTH):0] occupancy_o;

  crypto_result_tx #(.XLEN(XLEN), .ID_WIDTH(IDW), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .unit_valid_i(unit_valid_i), .unit_ready_o(unit_ready_o), .unit_id_i(unit_id_i),
    .unit_data_i(unit_data_i), .unit_rd_i(unit_rd_i), .unit_we_i(unit_we_i),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i), .result_id_o(result_id_o),
    .result_data_o(result_data_o), .result_rd_o(result_rd_o), .result_we_o(result_we_o),
    .occupancy_o(occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [IDW-1:0]  id;
    logic [XLEN-1:0] data;
    logic [4:0]      rd;
    logic            we;
  } res_t;

  typedef struct packed {
    logic [IDW-1:0]  id;
    logic [XLEN-1:0] data;
    logic [4:0]      rd;
    logic            we;
    logic            kill;
    logic            pre;
    logic            msg;
    logic            pushed;
  } rec_t;

  res_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_hs  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    unit_valid_i   = 1'b0;
    commit_valid_i = 1'b0;
  endtask

  task automatic push(input logic [IDW-1:0] id, input logic [XLEN-1:0] d,
                      input logic [4:0] rd, input logic we, input logic expect_out);
    unit_valid_i = 1'b1;
    unit_id_i    = id;
    unit_data_i  = d;
    unit_rd_i    = rd;
    unit_we_i    = we;
    if (expect_out) exp_q.push_back('{id: id, data: d, rd: rd, we: we});
  endtask

  task automatic msg(input logic [IDW-1:0] id, input logic kill);
    commit_valid_i = 1'b1;
    commit_id_i    = id;
    commit_kill_i  = kill;
  endtask

  // Monitor: checks every delivered result against the scoreboard and bus stability
  res_t hold;
  res_t mon_e;
  bit   hold_v = 1'b0;
  always @(negedge clk_i) begin
    if (rst_i) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("stable_valid", result_valid_o, 1);
        chk("stable_fields", {result_id_o, result_data_o, result_rd_o, result_we_o}, hold);
      end
      if (!result_valid_o)
        chk("idle_zero", {result_id_o, result_data_o, result_rd_o, result_we_o}, 0);
      if (result_valid_o && result_ready_i) begin
        n_hs++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: got id %0h, no result expected", result_id_o);
        end else begin
          mon_e = exp_q.pop_front();
          chk("result", {result_id_o, result_data_o, result_rd_o, result_we_o}, mon_e);
        end
      end
      hold_v = result_valid_o && !result_ready_i;
      hold   = {result_id_o, result_data_o, result_rd_o, result_we_o};
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1);
  end

  rec_t recs[$];
  int   free_ids[$];
  int   free_at[$];
  int   cand[$];
  int   n_cret;
  int   cyc;
  int   pidx;
  int   k;
  rec_t r;

  initial begin
    // reset state
    @(posedge clk_i);
    #1;
    chk("rst_ready", unit_ready_o, 0);
    chk("rst_valid", result_valid_o, 0);
    chk("rst_occ", occupancy_o, 0);
    tick();
    rst_i = 1'b0;
    #1;
    chk("ready_after_rst", unit_ready_o, 1);
    chk("occ_after_rst", occupancy_o, 0);

    // commit, then result
    result_ready_i = 1'b1;
    msg(3, 1'b0);
    tick();
    push(3, 64'hDEAD_BEEF, 5, 1'b1, 1'b1);
    tick();
    chk("t1_valid", result_valid_o, 1);
    chk("t1_occ", occupancy_o, 1);
    tick();
    chk("t1_occ_after", occupancy_o, 0);

    // backpressure and full
    result_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(4'(i), 64'h1000 + 64'(i), 5'(i + 8), 1'(i % 2), 1'b1);
      tick();
    end
    chk("full_ready", unit_ready_o, 0);
    chk("full_occ", occupancy_o, 4);
    for (int i = 0; i < 4; i++) begin
      msg(4'(i), 1'b0);
      tick();
    end
    repeat (3) begin
      chk("bp_id", result_id_o, 0);
      tick();
    end
    result_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", result_valid_o, 1);
      chk("drain_id", result_id_o, i);
      tick();
    end
    chk("drain_occ", occupancy_o, 0);

    // kill of a buffered entry
    push(1, 64'hAAAA, 1, 1'b1, 1'b0);
    tick();
    push(2, 64'hBBBB, 2, 1'b0, 1'b1);
    tick();
    msg(1, 1'b1);
    tick();
    msg(2, 1'b0);
    tick();
    chk("kill_occ", occupancy_o, 1);
    chk("kill_valid", result_valid_o, 1);
    chk("kill_id", result_id_o, 2);
    tick();
    chk("kill_occ0", occupancy_o, 0);

    // kill before the result arrives
    msg(7, 1'b1);
    tick();
    tick();
    tick();
    push(7, 64'h7777, 7, 1'b1, 1'b0);
    tick();
    chk("kp_occ1", occupancy_o, 1);
    chk("kp_valid", result_valid_o, 0);
    tick();
    chk("kp_occ0", occupancy_o, 0);
    msg(7, 1'b0);
    push(7, 64'h7070, 7, 1'b1, 1'b1);
    tick();
    chk("kp_reuse_valid", result_valid_o, 1);
    tick();
    chk("kp_reuse_occ0", occupancy_o, 0);

    // uncommitted head blocks a committed younger entry
    push(4, 64'h4444, 4, 1'b1, 1'b1);
    tick();
    push(5, 64'h5555, 6, 1'b1, 1'b1);
    tick();
    msg(5, 1'b0);
    tick();
    chk("hb_blocked0", result_valid_o, 0);
    tick();
    chk("hb_blocked1", result_valid_o, 0);
    msg(4, 1'b0);
    tick();
    chk("hb_first", result_id_o, 4);
    tick();
    chk("hb_second", result_id_o, 5);
    tick();
    chk("hb_occ0", occupancy_o, 0);

    // reset with results buffered
    result_ready_i = 1'b0;
    for (int i = 8; i < 11; i++) begin
      msg(4'(i), 1'b0);
      push(4'(i), 64'h8000 + 64'(i), 5'(i), 1'b1, 1'b1);
      tick();
    end
    chk("pre_rst_valid", result_valid_o, 1);
    chk("pre_rst_occ", occupancy_o, 3);
    rst_i = 1'b1;
    exp_q.delete();
    tick();
    rst_i = 1'b0;
    #1;
    chk("mid_rst_valid", result_valid_o, 0);
    chk("mid_rst_occ", occupancy_o, 0);
    result_ready_i = 1'b1;
    push(8, 64'h8888, 8, 1'b1, 1'b0);
    tick();
    tick();
    chk("replay_no_output", result_valid_o, 0);
    msg(8, 1'b0);
    exp_q.push_back('{id: 4'd8, data: 64'h8888, rd: 5'd8, we: 1'b1});
    tick();
    chk("recommit_valid", result_valid_o, 1);
    tick();
    chk("recommit_occ0", occupancy_o, 0);

    // randomized traffic: each instruction gets a fate (commit/kill) and a message timing
    for (int i = 0; i < 16; i++) begin
      free_ids.push_back(i);
      free_at.push_back(0);
    end
    n_cret = n_hs;
    cyc = 0;
    while (cyc < 4000 && (cyc < 2500 || recs.size() > 0)) begin
      result_ready_i = ($urandom_range(9) < 7);
      while (recs.size() > 0 && recs[0].pushed && recs[0].msg &&
             (recs[0].kill || n_hs > n_cret)) begin
        if (!recs[0].kill) n_cret++;
        free_ids.push_back(int'(recs[0].id));
        free_at.push_back(cyc + DEPTH + 2);
        void'(recs.pop_front());
      end
      if (cyc < 2500 && recs.size() < 6 && free_ids.size() > 0 && free_at[0] <= cyc &&
          $urandom_range(1) == 1) begin
        r.id     = 4'(free_ids.pop_front());
        void'(free_at.pop_front());
        r.data   = {$urandom, $urandom};
        r.rd     = 5'($urandom);
        r.we     = 1'($urandom);
        r.kill   = ($urandom_range(3) == 0);
        r.pre    = ($urandom_range(2) == 0);
        r.msg    = 1'b0;
        r.pushed = 1'b0;
        recs.push_back(r);
      end
      pidx = -1;
      foreach (recs[j]) if (!recs[j].pushed && pidx < 0) pidx = j;
      if (pidx >= 0 && unit_ready_o && (!recs[pidx].pre || recs[pidx].msg) &&
          $urandom_range(3) != 0) begin
        push(recs[pidx].id, recs[pidx].data, recs[pidx].rd, recs[pidx].we, !recs[pidx].kill);
        recs[pidx].pushed = 1'b1;
      end
      cand.delete();
      foreach (recs[j]) if (!recs[j].msg && (recs[j].pre || recs[j].pushed)) cand.push_back(j);
      if (cand.size() > 0 && $urandom_range(1) == 1) begin
        k = cand[$urandom_range(cand.size() - 1)];
        msg(recs[k].id, recs[k].kill);
        recs[k].msg = 1'b1;
      end
      tick();
      cyc++;
    end
    chk("rand_drained", recs.size(), 0);
    repeat (DEPTH + 4) tick();
    chk("final_exp_empty", exp_q.size(), 0);
    chk("final_occ", occupancy_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
